cbp_wide_add_sequencer: RTL and testbench

//   Multi-cycle sequencer computing a TOTAL_BITS-wide A+B+Cin on one shared CHUNK_BITS-wide

---
 rtl/cbp_wide_add_sequencer.sv | 129 ++++++++++++
 tb/tb_cbp_wide_add_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbp_wide_add_sequencer.sv
// Multi-cycle wide adder: one CHUNK_BITS carry-bypass adder reused LSB chunk first,
// with the inter-chunk carry held in a register. valid/ready on both sides.
module cbp_wide_add_sequencer #(
  parameter int unsigned TOTAL_BITS = 128,
  parameter int unsigned CHUNK_BITS = 32,
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] A,
  input  logic [TOTAL_BITS-1:0] B,
  input  logic                  Cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] Sum,
  output logic                  Cout,
  output logic                  busy
);
  localparam int unsigned NumChunks = TOTAL_BITS / CHUNK_BITS;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned StageW    = CHUNK_BITS / NUM_STAGES;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic                  accept, last_chunk;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;
  logic [TOTAL_BITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CHUNK_BITS-1:0] add_a, add_b, add_sum;
  logic                  add_cout;

  // Shared chunk adder: ripple inside each stage, stage carry bypassed when all bits propagate.
  always_comb begin
    logic c_stage, c_rip, prop;
    add_a   = a_q[idx_q*CHUNK_BITS +: CHUNK_BITS];
    add_b   = b_q[idx_q*CHUNK_BITS +: CHUNK_BITS];
    add_sum = '0;
    c_stage = carry_q;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      c_rip = c_stage;
      prop  = 1'b1;
      for (int i = 0; i < int'(StageW); i++) begin
        add_sum[s*StageW+i] = add_a[s*StageW+i] ^ add_b[s*StageW+i] ^ c_rip;
        c_rip = (add_a[s*StageW+i] & add_b[s*StageW+i]) |
                (c_rip & (add_a[s*StageW+i] ^ add_b[s*StageW+i]));
        prop  = prop & (add_a[s*StageW+i] ^ add_b[s*StageW+i]);
      end
      c_stage = prop ? c_stage : c_rip;
    end
    add_cout = c_stage;
  end

  assign last_chunk = (idx_q == LastIdx);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone: begin
        if (accept)         state_d = StRun;
        else if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    accept    = in_valid & in_ready;
    busy      = (state_q == StRun);
    out_valid = (state_q == StDone);
    Sum       = sum_q;
    Cout      = cout_q;
  end

  // Datapath next state; accept never coincides with RUN.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = A;
      b_d     = B;
      carry_d = Cin;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      sum_d[idx_q*CHUNK_BITS +: CHUNK_BITS] = add_sum;
      carry_d = add_cout;
      idx_d   = idx_q + 1'b1;
      if (last_chunk) cout_d = add_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_cbp_wide_add_sequencer.sv
// Scoreboard bench for cbp_wide_add_sequencer at 128/32, 64/64 and 96/16 chunkings.
module tb_cbp_wide_add_sequencer;
  localparam int Limit = 60000;
  localparam int NOps  = 2000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] a    [3];
  logic [127:0] b    [3];
  logic         ci   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] s    [3];
  logic         co   [3];
  logic         bz   [3];
  logic [127:0] s0;
  logic [63:0]  s1;
  logic [95:0]  s2;
  logic [128:0] exp_q [3][$];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  assign s[0] = s0;
  assign s[1] = {64'd0, s1};
  assign s[2] = {32'd0, s2};

  cbp_wide_add_sequencer #(.TOTAL_BITS(128), .CHUNK_BITS(32), .NUM_STAGES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0]), .B(b[0]),
    .Cin(ci[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .Sum(s0), .Cout(co[0]), .busy(bz[0])
  );
  cbp_wide_add_sequencer #(.TOTAL_BITS(64), .CHUNK_BITS(64), .NUM_STAGES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1][63:0]),
    .B(b[1][63:0]), .Cin(ci[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .Sum(s1),
    .Cout(co[1]), .busy(bz[1])
  );
  cbp_wide_add_sequencer #(.TOTAL_BITS(96), .CHUNK_BITS(16), .NUM_STAGES(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2][95:0]),
    .B(b[2][95:0]), .Cin(ci[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .Sum(s2),
    .Cout(co[2]), .busy(bz[2])
  );

  function automatic int tot_of(input int k);
    return (k == 0) ? 128 : (k == 1) ? 64 : 96;
  endfunction

  // {Cout, Sum zero-extended to 128 bits}
  function automatic logic [128:0] model(input int k, input logic [127:0] x, y, input logic c);
    logic [128:0] m, t;
    int w;
    w = tot_of(k);
    m = (129'd1 << w) - 129'd1;
    t = ({1'b0, x} & m) + ({1'b0, y} & m) + {128'd0, c};
    return {t[w], t[127:0] & m[127:0]};
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(7))
      0: r = '1;
      1: r = '0;
      2: r = r | 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000;
      default: ;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue0(input logic [127:0] x, y, input logic c);
    int n = 0;
    a[0] = x; b[0] = y; ci[0] = c; iv[0] = 1'b1;
    while (!ir[0] && n < 50) begin tick(); n++; end
    tick();
    iv[0] = 1'b0;
    exp_q[0].push_back(model(0, x, y, c));
  endtask

  task automatic wait_ov0(output int edges);
    edges = 0;
    while (!ov[0] && edges < 50) begin tick(); edges++; end
  endtask

  task automatic retire0();
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    logic [128:0] x;
    #3;
    n_vec++;
    if ({ov[0], bz[0], ir[0], co[0], s[0]} !== {3'b001, 129'd0}) begin
      n_err++;
      $display("FAIL reset_init got ov=%b bz=%b ir=%b co=%b sum=%h, want 0 0 1 0 0",
               ov[0], bz[0], ir[0], co[0], s[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    issue0(128'h1234_5678_9ABC_DEF0, 128'h0FED_CBA9, 1'b1);
    wait_ov0(e);
    x = exp_q[0].pop_front();
    n_vec++;
    if (!ov[0] || {co[0], s[0]} !== x) begin
      n_err++;
      $display("FAIL reset_preop got ov=%b %b_%h want 1 %h", ov[0], co[0], s[0], x);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ov[0], bz[0], ir[0], co[0], s[0]} !== {3'b001, 129'd0}) begin
      n_err++;
      $display("FAIL reset_async got ov=%b bz=%b ir=%b co=%b sum=%h, want 0 0 1 0 0",
               ov[0], bz[0], ir[0], co[0], s[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_ripple();
    int e;
    logic [128:0] x;
    issue0('1, 128'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bz[0] !== 1'b1 || ov[0] !== 1'b0) begin
        n_err++;
        $display("FAIL ripple_busy cycle %0d got bz=%b ov=%b want 1 0", i, bz[0], ov[0]);
      end
      tick();
    end
    n_vec++;
    if (ov[0] !== 1'b1 || bz[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ripple_latency got ov=%b bz=%b after 4 edges want 1 0", ov[0], bz[0]);
    end
    wait_ov0(e);
    x = exp_q[0].pop_front();
    n_vec++;
    if ({co[0], s[0]} !== x || x !== {1'b1, 128'd0}) begin
      n_err++;
      $display("FAIL ripple_result got %b_%h want %h", co[0], s[0], x);
    end
    retire0();
    n_vec++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ripple_retire got ov=%b ir=%b want 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_chunk_boundary();
    int e;
    logic [128:0] x;
    issue0(128'hFFFF_FFFF, 128'd0, 1'b1);
    wait_ov0(e);
    x = exp_q[0].pop_front();
    n_vec++;
    if ({co[0], s[0]} !== x) begin
      n_err++;
      $display("FAIL boundary32 got %b_%h want %h", co[0], s[0], x);
    end
    retire0();
    issue0(128'd1 << 96, 128'd1 << 96, 1'b0);
    wait_ov0(e);
    x = exp_q[0].pop_front();
    n_vec++;
    if ({co[0], s[0]} !== x) begin
      n_err++;
      $display("FAIL boundary96 got %b_%h want %h", co[0], s[0], x);
    end
    retire0();
  endtask

  task automatic test_back_to_back();
    int e;
    logic [128:0] x;
    issue0(128'hDEAD_BEEF_0123_4567_89AB_CDEF_FFFF_FFFF, 128'h1, 1'b1);
    wait_ov0(e);
    x = exp_q[0].pop_front();
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || {co[0], s[0]} !== x) begin
        n_err++;
        $display("FAIL hold cycle %0d got ov=%b ir=%b %b_%h want 1 0 %h",
                 i, ov[0], ir[0], co[0], s[0], x);
      end
      tick();
    end
    ordy[0] = 1'b1;
    a[0] = '1; b[0] = '1; ci[0] = 1'b1; iv[0] = 1'b1;
    #1;
    n_vec++;
    if (ir[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready got ir=%b want 1", ir[0]);
    end
    tick();
    iv[0] = 1'b0; ordy[0] = 1'b0;
    exp_q[0].push_back(model(0, '1, '1, 1'b1));
    n_vec++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_restart got ov=%b bz=%b want 0 1", ov[0], bz[0]);
    end
    wait_ov0(e);
    x = exp_q[0].pop_front();
    n_vec++;
    if (e !== 4 || {co[0], s[0]} !== x) begin
      n_err++;
      $display("FAIL b2b_result got edges=%0d %b_%h want 4 %h", e, co[0], s[0], x);
    end
    retire0();
  endtask

  task automatic test_reset_mid_run();
    int e;
    logic [128:0] x;
    issue0('1, 128'd3, 1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_q[0].delete();
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
        n_err++;
        $display("FAIL abort cycle %0d got ov=%b bz=%b ir=%b want 0 0 1", i, ov[0], bz[0], ir[0]);
      end
      tick();
    end
    issue0(128'd5, 128'd7, 1'b1);
    wait_ov0(e);
    x = exp_q[0].pop_front();
    n_vec++;
    if ({co[0], s[0]} !== x || x !== 129'd13) begin
      n_err++;
      $display("FAIL after_abort got %b_%h want %h", co[0], s[0], x);
    end
    retire0();
  endtask

  task automatic rand_drv(input int k);
    int sent = 0;
    int cyc = 0;
    logic acc;
    while (sent < NOps && cyc < Limit) begin
      // Data may change while waiting; only the value present at accept counts.
      if (!iv[k] || $urandom_range(1) == 0) begin
        a[k] = rnd128(); b[k] = rnd128(); ci[k] = 1'($urandom_range(1));
      end
      if (!iv[k] && $urandom_range(3) != 0) iv[k] = 1'b1;
      @(negedge clk);
      acc = iv[k] && ir[k];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        exp_q[k].push_back(model(k, a[k], b[k], ci[k]));
        sent++;
        iv[k] = 1'b0;
      end
    end
    iv[k] = 1'b0;
  endtask

  task automatic rand_mon(input int k);
    int got = 0;
    int cyc = 0;
    logic [128:0] x;
    while (got < NOps && cyc < Limit) begin
      ordy[k] = ($urandom_range(3) != 0);
      @(negedge clk);
      if (ov[k] && ordy[k]) begin
        n_vec++;
        if (exp_q[k].size() == 0) begin
          n_err++;
          $display("FAIL rand%0d unexpected result %b_%h", k, co[k], s[k]);
        end else begin
          x = exp_q[k].pop_front();
          if ({co[k], s[k]} !== x) begin
            n_err++;
            $display("FAIL rand%0d op %0d got %b_%h want %h", k, got, co[k], s[k], x);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++;
    if (got != NOps || exp_q[k].size() != 0) begin
      n_err++;
      $display("FAIL rand%0d count got %0d results, %0d pending, want %0d, 0",
               k, got, exp_q[k].size(), NOps);
    end
    ordy[k] = 1'b1;
  endtask

  task automatic test_random();
    fork
      rand_drv(0);
      rand_mon(0);
      rand_drv(1);
      rand_mon(1);
      rand_drv(2);
      rand_mon(2);
    join
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; a[k] = '0; b[k] = '0; ci[k] = 1'b0; ordy[k] = 1'b1;
    end
    ordy[0] = 1'b0;
    test_reset();
    test_full_ripple();
    test_chunk_boundary();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
